proc_seq_core: RTL and testbench

// Parametrised multi-cycle processor core: successor to the fixed-width proc top.

---
 rtl/proc_seq_core.sv | 176 +++++++++++++++++
 tb/tb_proc_seq_core.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_seq_core.sv
// Multi-cycle FETCH/EXEC processor core: req/ack instruction fetch, register file,
// ALU with zero flag, bounded call/data stack with sticky error, terminal HALT.
module proc_seq_core #(
    parameter int VALUE_WIDTH  = 8,
    parameter int PC_WIDTH     = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int REGS         = 4,
    parameter int STACK_DEPTH  = 8,
    localparam int RA = $clog2(REGS),
    localparam int IW = OPCODE_WIDTH + 2*RA + VALUE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    instr_req,
    output logic [PC_WIDTH-1:0]     instr_addr,
    input  logic                    instr_ack,
    input  logic [IW-1:0]           instr_data,
    output logic [OPCODE_WIDTH-1:0] op_code,
    output logic [VALUE_WIDTH-1:0]  alu_out,
    output logic                    zero_flag,
    output logic                    halted,
    output logic                    stack_err
);
    localparam int SW  = (VALUE_WIDTH > PC_WIDTH) ? VALUE_WIDTH : PC_WIDTH;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SAW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_CALL = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_RET  = OPCODE_WIDTH'(10);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUSH = OPCODE_WIDTH'(11);
    localparam logic [OPCODE_WIDTH-1:0] OP_POP  = OPCODE_WIDTH'(12);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(13);

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] op;
        logic [RA-1:0]           rd;
        logic [RA-1:0]           rs;
        logic [VALUE_WIDTH-1:0]  imm;
    } instr_t;

    logic [1:0]                         state;
    logic                               run;
    logic [PC_WIDTH-1:0]                pc;
    instr_t                             ir;
    logic [REGS-1:0][VALUE_WIDTH-1:0]   regs;
    logic [STACK_DEPTH-1:0][SW-1:0]     stack;
    logic [SPW-1:0]                     sp;

    logic [VALUE_WIDTH-1:0] rd_val, rs_val, res;
    logic [PC_WIDTH-1:0]    pc_inc, pc_next, imm_pc;
    logic [SW-1:0]          stk_top, push_val;
    logic                   wr_en, push_en, pop_en, err, halt_op, stk_full, stk_empty;

    // run holds req low for the first cycle out of reset
    assign instr_req  = run && (state == S_FETCH);
    assign instr_addr = pc;
    assign halted     = (state == S_HALT);

    always_comb begin
        rd_val    = regs[ir.rd];
        rs_val    = regs[ir.rs];
        pc_inc    = pc + 1'b1;
        imm_pc    = PC_WIDTH'(ir.imm);
        stk_full  = (sp == SPW'(STACK_DEPTH));
        stk_empty = (sp == '0);
        stk_top   = stack[SAW'(sp - 1'b1)];
        pc_next   = pc_inc;
        res       = '0;
        push_val  = '0;
        wr_en     = 1'b0;
        push_en   = 1'b0;
        pop_en    = 1'b0;
        err       = 1'b0;
        halt_op   = 1'b0;
        case (ir.op)
            OP_LDI:  begin res = ir.imm;          wr_en = 1'b1; end
            OP_ADD:  begin res = rd_val + rs_val; wr_en = 1'b1; end
            OP_SUB:  begin res = rd_val - rs_val; wr_en = 1'b1; end
            OP_AND:  begin res = rd_val & rs_val; wr_en = 1'b1; end
            OP_OR:   begin res = rd_val | rs_val; wr_en = 1'b1; end
            OP_XOR:  begin res = rd_val ^ rs_val; wr_en = 1'b1; end
            OP_JMP:  pc_next = imm_pc;
            OP_JZ:   if (zero_flag) pc_next = imm_pc;
            OP_CALL: begin
                if (stk_full) err = 1'b1;
                else begin
                    push_en  = 1'b1;
                    push_val = SW'(pc_inc);
                    pc_next  = imm_pc;
                end
            end
            OP_RET: begin
                if (stk_empty) err = 1'b1;
                else begin
                    pop_en  = 1'b1;
                    pc_next = PC_WIDTH'(stk_top);
                end
            end
            OP_PUSH: begin
                if (stk_full) err = 1'b1;
                else begin
                    push_en  = 1'b1;
                    push_val = SW'(rs_val);
                end
            end
            OP_POP: begin
                if (stk_empty) err = 1'b1;
                else begin
                    pop_en = 1'b1;
                    wr_en  = 1'b1;
                    res    = VALUE_WIDTH'(stk_top);
                end
            end
            OP_HALT: halt_op = 1'b1;
            default: ;
        endcase
        // a faulting stack op leaves PC on the offending instruction
        if (err) pc_next = pc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_FETCH;
            run       <= 1'b0;
            pc        <= '0;
            ir        <= '0;
            regs      <= '0;
            sp        <= '0;
            op_code   <= '0;
            alu_out   <= '0;
            zero_flag <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                S_FETCH: begin
                    if (instr_req && instr_ack) begin
                        ir    <= instr_data;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    op_code <= ir.op;
                    pc      <= pc_next;
                    if (wr_en) begin
                        regs[ir.rd] <= res;
                        alu_out     <= res;
                        zero_flag   <= (res == '0);
                    end
                    if (push_en)     sp <= sp + 1'b1;
                    else if (pop_en) sp <= sp - 1'b1;
                    if (err) stack_err <= 1'b1;
                    state <= (err || halt_op) ? S_HALT : S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state == S_EXEC && push_en) stack[SAW'(sp)] <= push_val;
    end

endmodule

// File: tb/tb_proc_seq_core.sv
// Scoreboard bench for proc_seq_core: directed programs plus random programs and
// random ack delays, checked against an instruction-level reference model.
module tb_proc_seq_core;
    localparam int VW = 8, PW = 8, OW = 4, NREG = 4, DEPTH = 8, IW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          instr_req;
    logic [PW-1:0] instr_addr;
    logic          instr_ack = 1'b0;
    logic [IW-1:0] instr_data = '0;
    logic [OW-1:0] op_code;
    logic [VW-1:0] alu_out;
    logic          zero_flag, halted, stack_err;

    proc_seq_core #(.VALUE_WIDTH(VW), .PC_WIDTH(PW), .OPCODE_WIDTH(OW),
                    .REGS(NREG), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data), .op_code(op_code),
        .alu_out(alu_out), .zero_flag(zero_flag), .halted(halted), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct { int op; int alu; int zf; int hlt; int serr; int pc; } exp_t;
    exp_t sbq[$];
    int total = 0, bad = 0;

    logic [IW-1:0] mem [256];
    int m_pc, m_zf, m_alu, m_hlt, m_serr, m_op;
    int m_regs [NREG];
    int m_stk[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs, input int imm);
        return IW'(((op & 15) << 12) | ((rd & 3) << 10) | ((rs & 3) << 8) | (imm & 255));
    endfunction

    task automatic model_reset();
        m_pc = 0; m_zf = 0; m_alu = 0; m_hlt = 0; m_serr = 0; m_op = 0;
        foreach (m_regs[i]) m_regs[i] = 0;
        m_stk.delete();
    endtask

    // executes the instruction at the model's own PC and queues the expected outcome
    task automatic model_step();
        int w, op, rd, rs, imm, r, wr, err, nxt;
        exp_t e;
        w = int'(mem[m_pc]);
        op = (w >> 12) & 15; rd = (w >> 10) & 3; rs = (w >> 8) & 3; imm = w & 255;
        r = 0; wr = 0; err = 0; nxt = (m_pc + 1) % 256;
        case (op)
            1:  begin r = imm; wr = 1; end
            2:  begin r = (m_regs[rd] + m_regs[rs]) % 256; wr = 1; end
            3:  begin r = (m_regs[rd] - m_regs[rs] + 256) % 256; wr = 1; end
            4:  begin r = m_regs[rd] & m_regs[rs]; wr = 1; end
            5:  begin r = m_regs[rd] | m_regs[rs]; wr = 1; end
            6:  begin r = m_regs[rd] ^ m_regs[rs]; wr = 1; end
            7:  nxt = imm;
            8:  if (m_zf != 0) nxt = imm;
            9:  if (m_stk.size() == DEPTH) err = 1; else begin m_stk.push_back(nxt); nxt = imm; end
            10: if (m_stk.size() == 0) err = 1; else nxt = m_stk.pop_back() % 256;
            11: if (m_stk.size() == DEPTH) err = 1; else m_stk.push_back(m_regs[rs]);
            12: if (m_stk.size() == 0) err = 1; else begin r = m_stk.pop_back() % 256; wr = 1; end
            13: m_hlt = 1;
            default: ;
        endcase
        if (err != 0) begin m_serr = 1; m_hlt = 1; nxt = m_pc; end
        if (wr != 0) begin m_regs[rd] = r; m_alu = r; m_zf = (r == 0) ? 1 : 0; end
        m_op = op;
        m_pc = nxt;
        e = '{m_op, m_alu, m_zf, m_hlt, m_serr, m_pc};
        sbq.push_back(e);
    endtask

    // monitor: a handshake seen at one negedge commits two negedges later
    bit p1 = 0, p2 = 0, stab = 0;
    logic [PW-1:0] last_addr = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            p1 = 0; p2 = 0; stab = 0;
        end else begin
            if (p2) begin
                chk("sb_pending", (sbq.size() > 0) ? 1 : 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("op_code", int'(op_code), e.op);
                    chk("alu_out", int'(alu_out), e.alu);
                    chk("zero_flag", int'(zero_flag), e.zf);
                    chk("halted", int'(halted), e.hlt);
                    chk("stack_err", int'(stack_err), e.serr);
                    if (e.hlt == 0) begin
                        chk("next_pc", int'(instr_addr), e.pc);
                        chk("req_fetch", int'(instr_req), 1);
                    end else begin
                        chk("req_halt", int'(instr_req), 0);
                    end
                end
            end
            if (p1) chk("req_exec", int'(instr_req), 0);
            if (stab && instr_req) chk("addr_stable", int'(instr_addr), int'(last_addr));
            stab = instr_req && !instr_ack;
            last_addr = instr_addr;
            p2 = p1;
            p1 = instr_req && instr_ack;
        end
    end

    task automatic do_reset(input bit ack_during);
        rst = 1'b0;
        instr_ack = ack_during;
        instr_data = enc(1, 0, 0, 77);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", int'(instr_req), 0);
        chk("rst_addr", int'(instr_addr), 0);
        chk("rst_op", int'(op_code), 0);
        chk("rst_alu", int'(alu_out), 0);
        chk("rst_zf", int'(zero_flag), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_serr", int'(stack_err), 0);
        sbq.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        instr_ack = 1'b0;
        @(negedge clk);
        chk("req_low_first", int'(instr_req), 0);
        @(posedge clk); #1;
        chk("req_rise", int'(instr_req), 1);
        chk("req_addr0", int'(instr_addr), 0);
    endtask

    task automatic run_prog(input int max_instr, input int mindly, input int maxdly, output int n);
        int wc, max_cyc, done;
        n = 0;
        wc = $urandom_range(maxdly, mindly);
        max_cyc = max_instr * (maxdly + 3) + 20;
        done = 0;
        for (int c = 0; c < max_cyc; c++) begin
            instr_ack = 1'b0;
            if (instr_req && n < max_instr && m_hlt == 0) begin
                if (wc == 0) begin
                    instr_ack = 1'b1;
                    instr_data = mem[instr_addr];
                    model_step();
                    n++;
                    wc = $urandom_range(maxdly, mindly);
                end else begin
                    wc--;
                end
            end
            if (!instr_ack && (m_hlt != 0 || n >= max_instr) && sbq.size() == 0) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
        end
        instr_ack = 1'b0;
        chk("prog_done", done, 1);
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) mem[a] = '0;
    endtask

    task automatic check_halt_idle();
        repeat (4) begin
            @(negedge clk);
            chk("halt_no_req", int'(instr_req), 0);
            chk("halt_held", int'(halted), 1);
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [IW-1:0] rand_instr();
        int op;
        op = $urandom_range(15, 0);
        if (op == 13 && $urandom_range(3, 0) != 0) op = 2;
        return enc(op, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(255, 0));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_mem();
        model_reset();
        do_reset(1'b1);

        // ALU wraparound, zero-wait then 4-cycle ack delay
        for (int pass = 0; pass < 2; pass++) begin
            clear_mem();
            mem[0] = enc(1, 0, 0, 200);
            mem[1] = enc(1, 1, 0, 56);
            mem[2] = enc(2, 0, 1, 0);
            mem[3] = enc(3, 0, 1, 0);
            mem[4] = enc(13, 0, 0, 0);
            if (pass != 0) do_reset(1'b0);
            run_prog(10, pass * 4, pass * 4, n);
            chk("t2_alu", int'(alu_out), 200);
            chk("t2_zf", int'(zero_flag), 0);
            chk("t2_count", n, 5);
        end

        // control flow: JZ taken/not-taken, CALL/RET, PC wrap past 0xFF
        clear_mem();
        mem[8'h00] = enc(8, 0, 0, 8'h30);
        mem[8'h01] = enc(1, 0, 0, 0);
        mem[8'h02] = enc(8, 0, 0, 4);
        mem[8'h03] = enc(13, 0, 0, 0);
        mem[8'h04] = enc(1, 1, 0, 1);
        mem[8'h05] = enc(9, 0, 0, 8'h40);
        mem[8'h40] = enc(10, 0, 0, 0);
        mem[8'h06] = enc(8, 0, 0, 8'h20);
        mem[8'h07] = enc(1, 3, 0, 0);
        mem[8'h08] = enc(7, 0, 0, 8'hFF);
        mem[8'hFF] = enc(0, 0, 0, 0);
        mem[8'h30] = enc(13, 0, 0, 0);
        mem[8'h20] = enc(13, 0, 0, 0);
        do_reset(1'b0);
        run_prog(20, 0, 2, n);
        chk("t4_count", n, 12);
        chk("t4_serr", int'(stack_err), 0);

        // stack overflow on the ninth push
        clear_mem();
        mem[0] = enc(1, 2, 0, 33);
        for (int a = 1; a <= DEPTH + 1; a++) mem[a] = enc(11, 0, 2, 0);
        do_reset(1'b0);
        run_prog(20, 0, 1, n);
        chk("t5_push_count", n, DEPTH + 2);
        chk("t5_ovf_err", int'(stack_err), 1);
        check_halt_idle();

        // stack underflow on a fresh run
        clear_mem();
        mem[0] = enc(12, 1, 0, 0);
        do_reset(1'b0);
        run_prog(5, 0, 0, n);
        chk("t5_unf_err", int'(stack_err), 1);
        check_halt_idle();

        // random programs with random ack delays
        for (int ep = 0; ep < 16; ep++) begin
            for (int a = 0; a < 256; a++) mem[a] = rand_instr();
            do_reset(ep[0]);
            run_prog(60, 0, ep % 4, n);
        end

        // reset while a fetch is pending with ack high
        for (int a = 0; a < 256; a++) mem[a] = enc(1, $urandom_range(3, 0), 0, $urandom_range(255, 1));
        mem[5] = enc(11, 0, 0, 0);
        do_reset(1'b0);
        run_prog(6, 0, 1, n);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_req_pending", int'(instr_req), 1);
        do_reset(1'b1);
        chk("t6_serr", int'(stack_err), 0);
        chk("t6_alu", int'(alu_out), 0);
        run_prog(4, 0, 0, n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
